ca_correlator: RTL
==================

Name: ca_correlator

Overview:
- Accumulate-and-dump correlator placed directly downstream of the C/A code generator in each tracking channel.
- Consumes the generator's serial chip and its chip index (code_shift), and builds Early, Prompt and Late replicas through a chip-spaced delay line.
- Multiplies signed baseband I/Q samples by each replica and integrates over one full code period (1023 chips).
- At each code epoch it dumps the six integrals, with a valid strobe, to the tracking-loop logic.

Parameters:
- SAMPLE_W, 4, width of signed two's-complement I/Q samples.
- ACC_W, 20, width of each signed accumulator and dump output.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  channel enable; low holds the block idle and cleared.
- chip_en  input  1  the generator advanced this cycle; ca_bit and code_shift show the new chip.
- ca_bit  input  1  current C/A chip from the generator.
- code_shift  input  10  index of the current chip, 0..1022.
- sample_valid  input  1  sample_i and sample_q are valid this cycle.
- sample_i  input  SAMPLE_W  signed in-phase sample.
- sample_q  input  SAMPLE_W  signed quadrature sample.
- acc_ie, acc_ip, acc_il  output  ACC_W  dumped I integrals for Early, Prompt and Late.
- acc_qe, acc_qp, acc_ql  output  ACC_W  dumped Q integrals for Early, Prompt and Late.
- dump_valid  output  1  one-cycle strobe; the acc_* outputs were updated this cycle.
- overflow  output  1  at least one accumulator saturated during the dumped period.

Behaviour:
- Reset (reset_n=0, asynchronous): all accumulators, all acc_* outputs, the delay registers p_bit and l_bit, dump_valid and overflow go to 0, and the sticky saturation flag clears.
- Chip mapping: 0 -> +1, 1 -> -1. A product is the sample when the replica chip is 0 and the negated sample when it is 1. Products are sign-extended to ACC_W before adding.
- Replicas:
  - Early = ca_bit.
  - Prompt = p_bit. Late = l_bit.
  - On chip_en=1: p_bit <= ca_bit and l_bit <= p_bit.
  - Resulting E-L spacing is 2 chips, each one chip from Prompt.
  - All three replicas are sampled combinationally in the same cycle, before the delay-line update.
- Accumulate: each cycle with enable=1 and sample_valid=1 and no epoch, every accumulator adds its product.
- Saturation:
  - Each add saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
  - Any saturation sets the sticky flag.
- Epoch: the cycle where enable=1, chip_en=1 and code_shift==0. In that cycle, at the clock edge:
  - acc_* outputs <= accumulator values as they stood before this cycle's sample.
  - overflow <= sticky flag.
  - Each accumulator <= this cycle's product if sample_valid=1, else 0.
  - Sticky flag <= saturation of that load (never saturates for ACC_W > SAMPLE_W).
  - dump_valid <= 1 for exactly the following cycle; it is 0 in every other cycle.
- Latency: dump appears 1 cycle after the epoch cycle. acc_* and overflow hold until the next dump.
- chip_en=1 with code_shift != 0: delay-line shift only, no dump.
- sample_valid=1 with chip_en=0: accumulate only; replicas unchanged.
- Simultaneous epoch and sample: the sample goes into the new period, never the dumped one.
- First epoch after reset or enable rise: dumps whatever partial period was collected (may be 0). Downstream logic discards it; the block does not flag it.
- enable=0:
  - Accumulators, p_bit, l_bit and the sticky flag cleared synchronously.
  - dump_valid=0.
  - acc_* and overflow keep their last dumped values.
- enable deasserted mid-period: the partial sum is lost; no dump is produced.
- code_shift values 1023 and above: treated as non-epoch, no error.
- reset_n asserted mid-period: immediate clear of everything; no dump.

Test Plan:
- Reset: drive reset_n=0 with nonzero samples, then release with enable=0 for 10 cycles -> all acc_*=0, dump_valid=0, overflow=0 throughout.
- Constant sample_i=+3, sample_q=-2, ca_bit=0, chip_en and sample_valid high every cycle, code_shift counting 0..1022 and wrapping:
  - second dump: acc_ip=3069, acc_qp=-2046, with acc_ie and acc_il equal to acc_ip.
  - dump_valid high for exactly 1 cycle, 1 cycle after code_shift==0.
- Alternating ca_bit 0,1,0,1 with sample_i=+1 every chip -> acc_ie=-1, acc_ip=+1, acc_il=-1 at the dump (1023 chips, odd count). This confirms the one-chip E/P/L offset.
- ACC_W=8, sample_i=+7, ca_bit=0 for a full period:
  - acc_ip=127 and overflow=1 at the dump.
  - The next period with sample_i=0 dumps acc_ip=0 with overflow=0.
- Epoch cycle with sample_valid=1 and sample_i=+5 -> the dumped acc_ip excludes the 5, and the next dump includes it.
- Drop enable mid-period, then raise it again -> no dump_valid while low; acc_* hold their previous dump. After re-enable, the first dump holds only the post-enable samples.

Source files
------------

// File: rtl/ca_correlator.sv
// Early/Prompt/Late accumulate-and-dump correlator for one GPS C/A tracking channel.
// Integrates I/Q samples against three chip-spaced code replicas and dumps at each code epoch.
module ca_correlator #(
    parameter int SAMPLE_W = 4,
    parameter int ACC_W    = 20
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       chip_en,
    input  logic                       ca_bit,
    input  logic [9:0]                 code_shift,
    input  logic                       sample_valid,
    input  logic signed [SAMPLE_W-1:0] sample_i,
    input  logic signed [SAMPLE_W-1:0] sample_q,
    output logic signed [ACC_W-1:0]    acc_ie,
    output logic signed [ACC_W-1:0]    acc_ip,
    output logic signed [ACC_W-1:0]    acc_il,
    output logic signed [ACC_W-1:0]    acc_qe,
    output logic signed [ACC_W-1:0]    acc_qp,
    output logic signed [ACC_W-1:0]    acc_ql,
    output logic                       dump_valid,
    output logic                       overflow
);

    typedef logic signed [ACC_W-1:0] acc_t;

    // Index order for the six channels: IE, IP, IL, QE, QP, QL.
    acc_t acc_q [6];
    acc_t acc_d [6];
    acc_t dmp_q [6];
    acc_t dmp_d [6];
    logic p_bit_q, p_bit_d;
    logic l_bit_q, l_bit_d;
    logic sticky_q, sticky_d;
    logic dv_q, dv_d;
    logic ov_q, ov_d;

    logic       epoch_s;
    logic [2:0] rep_s;
    acc_t       prod_s [6];
    acc_t       sum_s [6];
    logic [5:0] sat_s;

    // Chip 0 maps to +1, chip 1 to -1; sign-extend first so negating the most negative sample is exact.
    function automatic acc_t chip_product(input logic chip, input logic signed [SAMPLE_W-1:0] x);
        acc_t ext;
        ext = {{(ACC_W-SAMPLE_W){x[SAMPLE_W-1]}}, x};
        if (chip) begin
            chip_product = -ext;
        end else begin
            chip_product = ext;
        end
    endfunction

    // Returns {saturated, result}; the extra sum bit disagreeing with the MSB marks overflow.
    function automatic logic [ACC_W:0] sat_add(input acc_t a, input acc_t b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1]) begin
            sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
        end else begin
            sat_add = {1'b0, s[ACC_W-1:0]};
        end
    endfunction

    // Replica selection, products and saturating sums for all six channels.
    always_comb begin
        epoch_s = enable & chip_en & (code_shift == 10'd0);
        rep_s   = {l_bit_q, p_bit_q, ca_bit};
        for (int k = 0; k < 3; k++) begin
            prod_s[k]     = chip_product(rep_s[k], sample_i);
            prod_s[k + 3] = chip_product(rep_s[k], sample_q);
        end
        for (int k = 0; k < 6; k++) begin
            {sat_s[k], sum_s[k]} = sat_add(acc_q[k], prod_s[k]);
        end
    end

    // Next-state: clear when disabled, dump-and-reload on epoch, otherwise accumulate and shift.
    always_comb begin
        acc_d    = acc_q;
        dmp_d    = dmp_q;
        p_bit_d  = p_bit_q;
        l_bit_d  = l_bit_q;
        sticky_d = sticky_q;
        ov_d     = ov_q;
        dv_d     = 1'b0;
        if (!enable) begin
            for (int k = 0; k < 6; k++) begin
                acc_d[k] = '0;
            end
            p_bit_d  = 1'b0;
            l_bit_d  = 1'b0;
            sticky_d = 1'b0;
        end else if (epoch_s) begin
            // This cycle's sample opens the new period; it never lands in the dumped one.
            dmp_d    = acc_q;
            ov_d     = sticky_q;
            dv_d     = 1'b1;
            sticky_d = 1'b0;
            p_bit_d  = ca_bit;
            l_bit_d  = p_bit_q;
            for (int k = 0; k < 6; k++) begin
                if (sample_valid) begin
                    acc_d[k] = prod_s[k];
                end else begin
                    acc_d[k] = '0;
                end
            end
        end else begin
            if (sample_valid) begin
                acc_d    = sum_s;
                sticky_d = sticky_q | (|sat_s);
            end else begin
                acc_d = acc_q;
            end
            if (chip_en) begin
                p_bit_d = ca_bit;
                l_bit_d = p_bit_q;
            end else begin
                p_bit_d = p_bit_q;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 6; k++) begin
                acc_q[k] <= '0;
                dmp_q[k] <= '0;
            end
            p_bit_q  <= 1'b0;
            l_bit_q  <= 1'b0;
            sticky_q <= 1'b0;
            dv_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            dmp_q    <= dmp_d;
            p_bit_q  <= p_bit_d;
            l_bit_q  <= l_bit_d;
            sticky_q <= sticky_d;
            dv_q     <= dv_d;
            ov_q     <= ov_d;
        end
    end

    assign acc_ie     = dmp_q[0];
    assign acc_ip     = dmp_q[1];
    assign acc_il     = dmp_q[2];
    assign acc_qe     = dmp_q[3];
    assign acc_qp     = dmp_q[4];
    assign acc_ql     = dmp_q[5];
    assign dump_valid = dv_q;
    assign overflow   = ov_q;

endmodule
